niosiie_usb_ctl_pio: RTL and testbench
======================================

// Module: niosiie_usb_ctl_pio
// PURPOSE
//   Avalon-MM slave output port: the CPU-driven counterpart of the USB GPIO input port.
//   Drives the USB controller control pins (reset, wakeup, etc.) from the NIOS II.
//   Per-pin set/clear access, plus a hardware one-shot pulse generator so the
//   firmware can issue timed pulses (e.g. chip reset) without busy-waiting.
//   Sits on the system interconnect beside the input PIO; out_port goes to the top-level pins.
// PARAMETERS
//   WIDTH        4      number of output pins, 1..16
//   RESET_VALUE  4'h0   DATA register and out_port value after reset (WIDTH bits)
// PORTS
//   clk        in   1      system clock; the block's only clock
//   reset      in   1      synchronous, active-high reset
//   address    in   3      register word address
//   chipselect in   1      slave select
//   write      in   1      write strobe; acts only when chipselect=1
//   writedata  in   32     write data
//   readdata   out  32     registered read data
//   out_port   out  WIDTH  pin outputs
// BEHAVIOUR
//   Register map (word addresses):
//     0 DATA      RW  [WIDTH-1:0] output value
//     1 STATUS    [0] busy (RO); [1] overrun (write 1 to clear)
//     2 OUTSET    WO  DATA |= writedata[WIDTH-1:0]
//     3 OUTCLEAR  WO  DATA &= ~writedata[WIDTH-1:0]
//     4 PULSE     WO  mask = writedata[WIDTH-1:0], len = writedata[31:16]
//     5 PIN       RO  current out_port
//     6,7         reserved: reads 0, writes ignored
//   - Write-only and reserved addresses read 0. Unused upper readdata bits are 0.
//   - Reset: DATA=RESET_VALUE, busy=0, overrun=0, mask=0, count=0, readdata=0,
//     out_port=RESET_VALUE.
//   - Read timing: readdata updates every clk from the current address. No read strobe.
//     One-cycle latency: readdata valid the cycle after address is presented.
//     readdata reflects register state before any write taking effect at the same edge.
//   - Register writes take effect at the clk edge where chipselect & write = 1.
//   - out_port = DATA | (busy ? mask : 0). Driven only from registers, no combinational input path.
//   - Pulse FSM, two states:
//       IDLE: a PULSE write with len>0 loads mask and count=len, then moves to BUSY.
//             A PULSE write with len=0 is a no-op; mask is not loaded.
//       BUSY: on each edge, if count==1 go to IDLE (count=0), else count-=1.
//   - Pulse timing: busy and the forced-high mask bits last exactly len cycles,
//     starting the cycle after the write edge. len=65535 is the maximum. Counter does not wrap.
//   - PULSE write while BUSY: ignored (mask and count unchanged); sets overrun=1.
//   - Overrun vs clear at the same edge: if the ignored PULSE write and a STATUS W1C
//     land on the same edge, overrun ends up 1. This cannot occur with single-port Avalon.
//   - DATA, OUTSET and OUTCLEAR writes during BUSY update DATA immediately.
//     Masked pins stay high until the pulse ends, then follow DATA.
//   - Pulse forcing is OR-only: it can only drive pins high. Active-low pins are
//     pulsed low by inverting at the top level.
//   - Reset during BUSY: aborts the pulse; out_port = RESET_VALUE from the next cycle.
//   - Bits of writedata above WIDTH are ignored for DATA, OUTSET, OUTCLEAR and mask.
// TESTING
//   1 Reset, then read addr 0, 1 and 5 -> readdata = RESET_VALUE, 0, RESET_VALUE, each one cycle after address.
//   2 Write DATA=4'h5, OUTSET 4'h2, OUTCLEAR 4'h4 -> out_port 5, then 7, then 3; read PIN = 3.
//   3 DATA=0; PULSE mask=4'h1 len=10 -> out_port[0] high exactly cycles 1..10 after the write, busy mirrors it, then 0.
//   4 During the pulse of test 3: PULSE write -> ignored and overrun=1; write STATUS=2 -> overrun=0.
//     During the same pulse: DATA=4'h8 -> out_port=9 until the pulse ends, then 8.
//   5 PULSE len=0 -> busy stays 0, out_port unchanged.
//     PULSE len=65535 -> busy held high for 65535 cycles.
//   6 Assert reset mid-pulse -> out_port=RESET_VALUE and busy=0 on the next cycle; a new PULSE is then accepted.

Source files
------------

// File: rtl/niosiie_usb_ctl_pio.sv
// niosiie_usb_ctl_pio
// Avalon-MM slave output port driving the USB controller control pins.
// Offers direct DATA access, per-pin set/clear, a read-back of the live
// pins and a hardware one-shot pulse generator. The pulse forces selected
// pins high for a programmed number of cycles so firmware does not need to
// busy-wait around timed strobes such as a chip reset.
//
// Register map (word addresses):
//   0 DATA      RW  output value
//   1 STATUS    [0] busy (RO), [1] overrun (write 1 to clear)
//   2 OUTSET    WO  DATA |= bits
//   3 OUTCLEAR  WO  DATA &= ~bits
//   4 PULSE     WO  mask = [WIDTH-1:0], len = [31:16]
//   5 PIN       RO  current out_port
//   6,7         reserved
module niosiie_usb_ctl_pio #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_OUTSET   = 3'd2;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd3;
    localparam logic [2:0] ADDR_PULSE    = 3'd4;
    localparam logic [2:0] ADDR_PIN      = 3'd5;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Architectural state
    state_t            state_r;
    logic [WIDTH-1:0]  data_r;
    logic [WIDTH-1:0]  mask_r;
    logic [15:0]       count_r;
    logic              overrun_r;
    logic [31:0]       readdata_r;
    logic [WIDTH-1:0]  out_port_r;

    // Next-state and decode signals
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  data_nxt_s;
    logic [WIDTH-1:0]  mask_nxt_s;
    logic [15:0]       count_nxt_s;
    logic              overrun_nxt_s;
    logic [31:0]       rd_mux_s;
    logic [WIDTH-1:0]  pin_nxt_s;

    logic              wr_en_s;
    logic              pulse_wr_s;
    logic              status_wr_s;
    logic              pulse_reject_s;
    logic              busy_s;
    logic              busy_nxt_s;
    logic [WIDTH-1:0]  wr_bits_s;
    logic [15:0]       pulse_len_s;

    // Writedata bits between WIDTH and 15 carry no meaning for this port.
    logic              unused_s;
    assign unused_s = ^writedata;

    assign wr_en_s     = chipselect & write;
    assign pulse_wr_s  = wr_en_s & (address == ADDR_PULSE);
    assign status_wr_s = wr_en_s & (address == ADDR_STATUS);
    assign wr_bits_s   = writedata[WIDTH-1:0];
    assign pulse_len_s = writedata[31:16];
    assign busy_s      = (state_r == ST_BUSY);
    assign busy_nxt_s  = (state_nxt_s == ST_BUSY);

    // DATA register update from DATA / OUTSET / OUTCLEAR writes; legal while a pulse runs.
    always_comb begin
        data_nxt_s = data_r;
        if (wr_en_s) begin
            case (address)
                ADDR_DATA:     data_nxt_s = wr_bits_s;
                ADDR_OUTSET:   data_nxt_s = data_r | wr_bits_s;
                ADDR_OUTCLEAR: data_nxt_s = data_r & ~wr_bits_s;
                default:       data_nxt_s = data_r;
            endcase
        end else begin
            data_nxt_s = data_r;
        end
    end

    // Pulse sequencer next state: load on an accepted PULSE write, count down while busy.
    always_comb begin
        state_nxt_s    = state_r;
        mask_nxt_s     = mask_r;
        count_nxt_s    = count_r;
        pulse_reject_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A zero-length request is a no-op and leaves the mask alone.
                if (pulse_wr_s && (pulse_len_s != 16'd0)) begin
                    state_nxt_s = ST_BUSY;
                    mask_nxt_s  = wr_bits_s;
                    count_nxt_s = pulse_len_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A second request cannot be queued; it is dropped and flagged.
                pulse_reject_s = pulse_wr_s;
                if (count_r == 16'd1) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = 16'd0;
                end else begin
                    state_nxt_s = ST_BUSY;
                    count_nxt_s = count_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = 16'd0;
            end
        endcase
    end

    // Overrun flag: a dropped pulse request wins over a same-edge write-1-to-clear.
    always_comb begin
        overrun_nxt_s = overrun_r;
        if (pulse_reject_s) begin
            overrun_nxt_s = 1'b1;
        end else if (status_wr_s && writedata[1]) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Read multiplexer on pre-write state; write-only and reserved words read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_DATA:   rd_mux_s = {{(32-WIDTH){1'b0}}, data_r};
            ADDR_STATUS: rd_mux_s = {30'd0, overrun_r, busy_s};
            ADDR_PIN:    rd_mux_s = {{(32-WIDTH){1'b0}}, out_port_r};
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Pin value for the next cycle; the pulse mask can only force pins high.
    always_comb begin
        pin_nxt_s = data_nxt_s;
        if (busy_nxt_s) begin
            pin_nxt_s = data_nxt_s | mask_nxt_s;
        end else begin
            pin_nxt_s = data_nxt_s;
        end
    end

    // Pulse sequencer state register; reset aborts any pulse in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mask_r  <= ZERO_W;
            count_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            mask_r  <= mask_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Control/status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r    <= RESET_VALUE;
            overrun_r <= 1'b0;
        end else begin
            data_r    <= data_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    // Registered outputs: pins and read data, neither with a combinational input path.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'd0;
            out_port_r <= RESET_VALUE;
        end else begin
            readdata_r <= rd_mux_s;
            out_port_r <= pin_nxt_s;
        end
    end

    assign readdata = readdata_r;
    assign out_port = out_port_r;

endmodule

// File: tb/tb_niosiie_usb_ctl_pio.sv
// Testbench for niosiie_usb_ctl_pio.
// A driver issues one bus cycle per clock and pushes the expected readdata
// and out_port for that edge into a queue; a monitor on the falling edge
// pops and compares. The reference model tracks the pulse as an absolute
// window of clock edges rather than a countdown.
module tb_niosiie_usb_ctl_pio;

    localparam int          W  = 4;
    localparam logic [W-1:0] RV = 4'h6;

    logic           clk = 1'b0;
    logic           reset;
    logic [2:0]     address;
    logic           chipselect;
    logic           write;
    logic [31:0]    writedata;
    logic [31:0]    readdata;
    logic [W-1:0]   out_port;

    always #5 clk = ~clk;

    niosiie_usb_ctl_pio #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    typedef struct packed {
        logic [31:0]  rd;
        logic [W-1:0] pin;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model: pins forced during edges [m_start, m_stop)
    logic [W-1:0] m_data    = RV;
    logic [W-1:0] m_mask    = 4'h0;
    logic         m_overrun = 1'b0;
    longint       m_n       = 0;
    longint       m_start   = 0;
    longint       m_stop    = 0;

    function automatic logic m_busy(input longint k);
        return (k >= m_start) && (k < m_stop);
    endfunction

    task automatic drive(input logic rst, input logic cs, input logic wr,
                         input logic [2:0] a, input logic [31:0] wd);
        longint      n;
        logic        bp;
        logic [31:0] rd;
        logic [15:0] len;
        exp_t        e;
        n  = m_n + 1;
        bp = m_busy(m_n);
        case (a)
            3'd0:    rd = {28'd0, m_data};
            3'd1:    rd = {30'd0, m_overrun, bp};
            3'd5:    rd = {28'd0, m_data | (bp ? m_mask : 4'h0)};
            default: rd = 32'd0;
        endcase
        if (rst) begin
            m_data    = RV;
            m_mask    = 4'h0;
            m_overrun = 1'b0;
            m_start   = 0;
            m_stop    = 0;
            rd        = 32'd0;
        end else if (cs && wr) begin
            case (a)
                3'd0: m_data = wd[W-1:0];
                3'd1: if (wd[1]) m_overrun = 1'b0;
                3'd2: m_data = m_data | wd[W-1:0];
                3'd3: m_data = m_data & ~wd[W-1:0];
                3'd4: begin
                    len = wd[31:16];
                    if (bp) begin
                        m_overrun = 1'b1;
                    end else if (len != 16'd0) begin
                        m_mask  = wd[W-1:0];
                        m_start = n;
                        m_stop  = n + longint'(len);
                    end
                end
                default: ;
            endcase
        end
        e.rd  = rd;
        e.pin = m_data | (m_busy(n) ? m_mask : 4'h0);
        exp_q.push_back(e);
        m_n = n;
        reset      = rst;
        chipselect = cs;
        write      = wr;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        drive(1'b0, 1'b1, 1'b1, a, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        drive(1'b0, 1'b1, 1'b0, a, $urandom);
    endtask

    // Monitor: compare each edge's outputs against the scoreboard entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 1;
            if (readdata !== mon_e.rd) begin
                errors = errors + 1;
                $display("FAIL readdata t=%0t got=%h want=%h", $time, readdata, mon_e.rd);
            end
            checks = checks + 1;
            if (out_port !== mon_e.pin) begin
                errors = errors + 1;
                $display("FAIL out_port t=%0t got=%h want=%h", $time, out_port, mon_e.pin);
            end
        end
    end

    initial begin
        logic [31:0] wd;
        logic [2:0]  a;
        // Reset and reset-value reads
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        rd_reg(3'd0); rd_reg(3'd1); rd_reg(3'd5); rd_reg(3'd0);
        // DATA / OUTSET / OUTCLEAR and upper-bit masking
        wr_reg(3'd0, 32'hFFFF_FFF5);
        wr_reg(3'd2, 32'h0000_0002);
        wr_reg(3'd3, 32'h0000_0004);
        rd_reg(3'd5); rd_reg(3'd0);
        // Write without chipselect is ignored
        drive(1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_000F);
        rd_reg(3'd0);
        // Pulse len=10 with overrun, W1C and DATA update during the pulse
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd4, {16'd10, 16'h0001});
        for (int i = 0; i < 3; i++) rd_reg(3'd1);
        wr_reg(3'd4, {16'd5, 16'h000F});
        rd_reg(3'd1); rd_reg(3'd1);
        wr_reg(3'd1, 32'h0000_0002);
        rd_reg(3'd1);
        wr_reg(3'd0, 32'h0000_0008);
        for (int i = 0; i < 8; i++) rd_reg(3'd5);
        // Zero-length pulse is a no-op
        wr_reg(3'd4, {16'd0, 16'h000F});
        rd_reg(3'd1); rd_reg(3'd5);
        // Reset mid-pulse, then a new pulse is accepted
        wr_reg(3'd4, {16'd20, 16'h0003});
        rd_reg(3'd5); rd_reg(3'd5); rd_reg(3'd1);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        rd_reg(3'd5);
        wr_reg(3'd4, {16'd3, 16'h0004});
        for (int i = 0; i < 5; i++) rd_reg(3'd1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd4) wd[31:16] = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 2) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
            end else begin
                drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, wd);
            end
        end
        // Maximum-length pulse
        wr_reg(3'd1, 32'h0000_0002);
        wr_reg(3'd0, 32'h0000_0000);
        wr_reg(3'd4, {16'hFFFF, 16'h000A});
        for (int i = 0; i < 65540; i++) begin
            rd_reg(($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5);
        end
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
